// File: rtl/lau_pkg.sv
// Shared constants, state encoding and sizing helpers for the LAU config loader.
package lau_pkg;

    // Word header codes carried in bits [133:132]
    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    // TYPE word identification
    localparam logic [15:0] TYPE_ID = 16'hff01;
    localparam logic [3:0]  SUBTYPE = 4'h2;

    // Error codes reported on out_lau_err_code
    localparam logic [1:0] ERR_BAD_TYPE = 2'd1;
    localparam logic [1:0] ERR_FRAMING  = 2'd2;
    localparam logic [1:0] ERR_NO_TAIL  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_META1,
        ST_TYPE,
        ST_EMETA0,
        ST_EMETA1,
        ST_GCL,
        ST_PGM,
        ST_FSM,
        ST_SSM,
        ST_DROP
    } lau_state_t;

    // PGM section length: one global word, tb words (4 ch each), len words (8 ch each)
    function automatic int pgm_words(input int num_ch);
        return 1 + (num_ch + 3) / 4 + (num_ch + 7) / 8;
    endfunction

endpackage

// File: rtl/lau_cfg_shadow.sv
// Shadow + committed register bank. Shadows fill while a packet is parsed;
// commit copies them to the outputs, revert reloads them from the outputs.
module lau_cfg_shadow
    import lau_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int RULE_W = 104,
    parameter int CW     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [127:0]             data,
    input  logic [CW-1:0]            idx,
    input  logic                     meta_we,
    input  logic                     pgm_we,
    input  logic                     fsm_we,
    input  logic                     commit,
    input  logic                     revert,
    output logic                     stop_shadow,
    output logic [3:0]               seq,
    output logic                     test_stop,
    output logic [19:0]              slot_cycle,
    output logic [NUM_CH*12-1:0]     pkt_len,
    output logic [NUM_CH*16-1:0]     tb_size,
    output logic [NUM_CH*16-1:0]     tb_rate,
    output logic [NUM_CH*RULE_W-1:0] rule_5tuple,
    output logic [NUM_CH*RULE_W-1:0] mask,
    output logic [15:0]              samp_freq
);
    localparam int TB_WORDS = (NUM_CH + 3) / 4;

    logic [3:0]  seq_sh_reg;
    logic        stop_sh_reg;
    logic [19:0] slot_sh_reg;
    logic        pgm0_we;

    assign pgm0_we     = pgm_we && (idx == '0);
    assign stop_shadow = stop_sh_reg;

    // Global shadow fields: seq from TYPE, stop/slot from PGM word 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_sh_reg  <= '0;
            stop_sh_reg <= 1'b1;
            slot_sh_reg <= '0;
        end else if (revert) begin
            seq_sh_reg  <= seq;
            stop_sh_reg <= test_stop;
            slot_sh_reg <= slot_cycle;
        end else begin
            if (meta_we) begin
                seq_sh_reg <= data[11:8];
            end
            if (pgm0_we) begin
                stop_sh_reg <= data[32];
                slot_sh_reg <= data[19:0];
            end
        end
    end

    // Global committed fields; the sample divisor comes straight from the tail word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq        <= '0;
            test_stop  <= 1'b1;
            slot_cycle <= '0;
            samp_freq  <= 16'd1;
        end else if (commit) begin
            seq        <= seq_sh_reg;
            test_stop  <= stop_sh_reg;
            slot_cycle <= slot_sh_reg;
            samp_freq  <= (data[15:0] == 16'd0) ? 16'd1 : data[15:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam int TB_IDX  = 1 + gi / 4;
            localparam int TB_LSB  = 32 * (gi % 4);
            localparam int LEN_IDX = 1 + TB_WORDS + gi / 8;
            localparam int LEN_LSB = 16 * (gi % 8);

            logic [11:0]       len_sh_reg,  len_reg;
            logic [15:0]       size_sh_reg, size_reg;
            logic [15:0]       rate_sh_reg, rate_reg;
            logic [RULE_W-1:0] rule_sh_reg, rule_reg;
            logic [RULE_W-1:0] mask_sh_reg, mask_reg;

            // Per-channel shadows, selected by word index within PGM / FSM sections
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    len_sh_reg  <= '0;
                    size_sh_reg <= 16'h7fff;
                    rate_sh_reg <= '0;
                    rule_sh_reg <= '0;
                    mask_sh_reg <= '1;
                end else if (revert) begin
                    len_sh_reg  <= len_reg;
                    size_sh_reg <= size_reg;
                    rate_sh_reg <= rate_reg;
                    rule_sh_reg <= rule_reg;
                    mask_sh_reg <= mask_reg;
                end else begin
                    if (pgm_we && idx == CW'(TB_IDX)) begin
                        size_sh_reg <= data[TB_LSB+16 +: 16];
                        rate_sh_reg <= data[TB_LSB +: 16];
                    end
                    if (pgm_we && idx == CW'(LEN_IDX)) begin
                        len_sh_reg <= data[LEN_LSB +: 12];
                    end
                    if (fsm_we && idx == CW'(2 * gi)) begin
                        rule_sh_reg <= data[RULE_W-1:0];
                    end
                    if (fsm_we && idx == CW'(2 * gi + 1)) begin
                        mask_sh_reg <= data[RULE_W-1:0];
                    end
                end
            end

            // Per-channel committed values
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    len_reg  <= '0;
                    size_reg <= 16'h7fff;
                    rate_reg <= '0;
                    rule_reg <= '0;
                    mask_reg <= '1;
                end else if (commit) begin
                    len_reg  <= len_sh_reg;
                    size_reg <= size_sh_reg;
                    rate_reg <= rate_sh_reg;
                    rule_reg <= rule_sh_reg;
                    mask_reg <= mask_sh_reg;
                end
            end

            assign pkt_len[12*gi +: 12]         = len_reg;
            assign tb_size[16*gi +: 16]         = size_reg;
            assign tb_rate[16*gi +: 16]         = rate_reg;
            assign rule_5tuple[RULE_W*gi +: RULE_W] = rule_reg;
            assign mask[RULE_W*gi +: RULE_W]    = mask_reg;
        end
    endgenerate

endmodule

// File: rtl/lau_cfg_loader.sv
// LAU config packet parser: streams GCL entries into the inactive RAM bank and
// loads channel config into shadows; a well-formed tail commits both atomically.
module lau_cfg_loader
    import lau_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int GCL_DEPTH = 32,
    parameter int GCL_AW    = 5,
    parameter int RULE_W    = 104
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [133:0]             in_lau_data,
    input  logic                     in_lau_data_wr,
    output logic                     out_lau_gc_wr,
    output logic [GCL_AW:0]          out_lau_gc_addr,
    output logic [127:0]             out_lau_gc,
    output logic                     out_lau_gcl_bank,
    output logic [3:0]               out_lau_gcl_array_seq,
    output logic                     out_lau_test_stop,
    output logic [19:0]              out_lau_gcl_time_slot_cycle,
    output logic [NUM_CH*12-1:0]     out_lau_pkt_len,
    output logic [NUM_CH*16-1:0]     out_lau_tb_size,
    output logic [NUM_CH*16-1:0]     out_lau_tb_rate,
    output logic [NUM_CH*RULE_W-1:0] out_lau_rule_5tuple,
    output logic [NUM_CH*RULE_W-1:0] out_lau_mask,
    output logic [15:0]              out_lau_samp_freq,
    output logic                     out_lau_update_finish,
    output logic                     out_lau_err,
    output logic [1:0]               out_lau_err_code
);
    localparam int CNT_MAX = (GCL_DEPTH > 2 * NUM_CH) ? GCL_DEPTH : 2 * NUM_CH;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int P_WORDS = pgm_words(NUM_CH);

    lau_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          is_head, is_tail, type_ok;
    logic          meta_we, pgm_we, fsm_we, commit, revert, gc_fire, err_fire;
    logic [1:0]    err_val;
    logic          stop_shadow;
    logic          unused_hdr_pad;

    assign is_head        = (in_lau_data[133:132] == HDR_HEAD);
    assign is_tail        = (in_lau_data[133:132] == HDR_TAIL);
    assign type_ok        = (in_lau_data[31:16] == TYPE_ID) && (in_lau_data[15:12] == SUBTYPE);
    assign unused_hdr_pad = ^in_lau_data[131:128];

    // State and word counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state decode and load/commit/revert strobes; nothing moves without wr
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        meta_we    = 1'b0;
        pgm_we     = 1'b0;
        fsm_we     = 1'b0;
        commit     = 1'b0;
        revert     = 1'b0;
        gc_fire    = 1'b0;
        err_fire   = 1'b0;
        err_val    = ERR_FRAMING;
        if (in_lau_data_wr) begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_head) begin
                        state_next = ST_META1;
                        cnt_next   = '0;
                    end
                end
                ST_DROP: begin
                    if (is_head) begin
                        state_next = ST_META1;
                        cnt_next   = '0;
                    end else if (is_tail) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    // A head mid-packet restarts; a tail before SSM aborts to IDLE
                    if (is_head || (is_tail && state_reg != ST_SSM)) begin
                        err_fire   = 1'b1;
                        err_val    = ERR_FRAMING;
                        revert     = 1'b1;
                        cnt_next   = '0;
                        state_next = is_head ? ST_META1 : ST_IDLE;
                    end else begin
                        case (state_reg)
                            ST_META1:  state_next = ST_TYPE;
                            ST_TYPE: begin
                                if (type_ok) begin
                                    meta_we    = 1'b1;
                                    state_next = ST_EMETA0;
                                end else begin
                                    err_fire   = 1'b1;
                                    err_val    = ERR_BAD_TYPE;
                                    revert     = 1'b1;
                                    state_next = ST_DROP;
                                end
                            end
                            ST_EMETA0: state_next = ST_EMETA1;
                            ST_EMETA1: begin
                                state_next = ST_GCL;
                                cnt_next   = '0;
                            end
                            ST_GCL: begin
                                gc_fire = 1'b1;
                                if (cnt_reg == CW'(GCL_DEPTH - 1)) begin
                                    state_next = ST_PGM;
                                    cnt_next   = '0;
                                end else begin
                                    cnt_next = cnt_reg + CW'(1);
                                end
                            end
                            ST_PGM: begin
                                pgm_we = 1'b1;
                                if (cnt_reg == CW'(P_WORDS - 1)) begin
                                    state_next = ST_FSM;
                                    cnt_next   = '0;
                                end else begin
                                    cnt_next = cnt_reg + CW'(1);
                                end
                            end
                            ST_FSM: begin
                                fsm_we = 1'b1;
                                if (cnt_reg == CW'(2 * NUM_CH - 1)) begin
                                    state_next = ST_SSM;
                                    cnt_next   = '0;
                                end else begin
                                    cnt_next = cnt_reg + CW'(1);
                                end
                            end
                            ST_SSM: begin
                                if (is_tail) begin
                                    commit     = 1'b1;
                                    state_next = ST_IDLE;
                                end else begin
                                    err_fire   = 1'b1;
                                    err_val    = ERR_NO_TAIL;
                                    revert     = 1'b1;
                                    state_next = ST_DROP;
                                end
                            end
                            default: state_next = ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // GCL write port, one cycle behind the word; always aimed at the inactive bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_lau_gc_wr   <= 1'b0;
            out_lau_gc_addr <= '0;
            out_lau_gc      <= '0;
        end else begin
            out_lau_gc_wr <= gc_fire;
            if (gc_fire) begin
                out_lau_gc_addr <= {~out_lau_gcl_bank, cnt_reg[GCL_AW-1:0]};
                out_lau_gc      <= in_lau_data[127:0];
            end
        end
    end

    // Bank flip, completion pulse and error reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_lau_gcl_bank      <= 1'b0;
            out_lau_update_finish <= 1'b0;
            out_lau_err           <= 1'b0;
            out_lau_err_code      <= '0;
        end else begin
            out_lau_update_finish <= commit && !stop_shadow;
            out_lau_err           <= err_fire;
            if (commit) begin
                out_lau_gcl_bank <= ~out_lau_gcl_bank;
            end
            if (err_fire) begin
                out_lau_err_code <= err_val;
            end
        end
    end

    lau_cfg_shadow #(
        .NUM_CH (NUM_CH),
        .RULE_W (RULE_W),
        .CW     (CW)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .data        (in_lau_data[127:0]),
        .idx         (cnt_reg),
        .meta_we     (meta_we),
        .pgm_we      (pgm_we),
        .fsm_we      (fsm_we),
        .commit      (commit),
        .revert      (revert),
        .stop_shadow (stop_shadow),
        .seq         (out_lau_gcl_array_seq),
        .test_stop   (out_lau_test_stop),
        .slot_cycle  (out_lau_gcl_time_slot_cycle),
        .pkt_len     (out_lau_pkt_len),
        .tb_size     (out_lau_tb_size),
        .tb_rate     (out_lau_tb_rate),
        .rule_5tuple (out_lau_rule_5tuple),
        .mask        (out_lau_mask),
        .samp_freq   (out_lau_samp_freq)
    );

endmodule
